sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Multi-port front end that shares one sdram_controller between NUM_PORTS requesters.
- Picks one pending read/write request, latches its command and address, and drives the controller's user command interface.
- Routes burst read data, write-data pacing and completion back to the granted port only.
- Sits between client blocks (framebuffer, DMA, CPU bridge) and sdram_controller; the controller has no busy output, so the arbiter infers acceptance from the controller's responses.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- USER_ADDRESS_WIDTH, 24, width of the controller's data_address.
- DATA_WIDTH, 16, width of the SDRAM data word.

Ports:
- clk  input  1  controller clock.
- reset  input  1  synchronous, active-high.
- port_req  input  NUM_PORTS  per-port request level.
- port_command  input  NUM_PORTS x 2  per-port command: 1=write, 2=read; 0 and 3 are ignored (no request).
- port_address  input  NUM_PORTS x USER_ADDRESS_WIDTH  per-port address.
- port_write_data  input  NUM_PORTS x DATA_WIDTH  per-port write word (live, not latched).
- port_grant  output  NUM_PORTS  one-cycle pulse: request latched.
- port_read_data  output  DATA_WIDTH  broadcast read data.
- port_read_valid  output  NUM_PORTS  read word valid, granted port only.
- port_write_done  output  NUM_PORTS  write word consumed, granted port only.
- port_complete  output  NUM_PORTS  one-cycle pulse at end of transfer.
- command  output  2  to controller.
- data_address  output  USER_ADDRESS_WIDTH  to controller.
- data_write  output  DATA_WIDTH  to controller.
- data_read  input  DATA_WIDTH  from controller.
- data_read_valid  input  1  from controller.
- data_write_done  input  1  from controller.

Behaviour:
- All outputs are registered except data_write, port_read_data, port_read_valid and port_write_done, which are combinational muxes/gates of the current grant.
- Reset values: command=0, data_address=0, grant/complete/valid/done=0, rr pointer=0, state=ARB_IDLE, owner=0.
- States: ARB_IDLE, ARB_ISSUE, ARB_DRAIN.
- ARB_IDLE:
  - If any port has port_req=1 with port_command of 1 or 2, choose a winner.
  - Next cycle: port_grant[winner]=1 for one cycle; command and data_address latched from the winner; owner=winner; state -> ARB_ISSUE.
  - Latency from request to command driven: 1 clk.
- ARB_ISSUE:
  - Hold command and data_address stable; the controller accepts whenever it reaches its idle state, which may be delayed by refresh.
  - Acceptance = first cycle with data_write_done=1 (write) or data_read_valid=1 (read).
  - On acceptance: command -> 0 registered, state -> ARB_DRAIN.
  - data_address stays latched until back in ARB_IDLE, because the controller re-samples it at the column command.
- ARB_DRAIN:
  - When the controller's response falls to 0, pulse port_complete[owner] and return to ARB_IDLE.
  - A new grant is possible the cycle after port_complete; the controller handles its own precharge/recovery and accepts the next command only once idle.
- Routing:
  - data_write = port_write_data[owner] in ARB_ISSUE and ARB_DRAIN, else 0.
  - port_write_done[owner] = data_write_done. The requester advances to its next burst word on each high cycle.
  - port_read_valid[owner] = data_read_valid; port_read_data = data_read.
  - Non-owners always see 0.
- Requesters hold req, command and address stable until port_grant; req may stay high for back-to-back transfers.
- Simultaneous events:
  - Requests arriving during ARB_ISSUE or ARB_DRAIN wait.
  - A request withdrawn before grant is never issued.
- Arbitration is round-robin: search starts at rr pointer; after a grant, pointer = winner+1 mod NUM_PORTS.
- Reset mid-transfer:
  - Arbiter returns to ARB_IDLE with command=0.
  - Controller responses arriving after reset are discarded (no owner valid until next grant).
  - No port_complete is issued.

Optional Feature:
- SDRAM_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest port index wins; rr pointer logic is removed.
- Undefined: round-robin as above.

Decomposition:
- Package sdram_arbiter_pkg:
  - command constants CMD_IDLE=2'd0, CMD_WRITE=2'd1, CMD_READ=2'd2;
  - state enum arb_state_t.
- One sub-module, sdram_arbiter_pick:
  - combinational winner select from request vector and pointer;
  - outputs one-hot winner and a valid flag;
  - the macro selects between the two select algorithms inside it.

Test Plan:
- Single read: port 1 req, command=2, address 0x000123; read burst length 4 -> grant[1] one cycle after req, command=2 with address 0x000123 until the first data_read_valid, 4 port_read_valid[1] beats matching model data, then complete[1] pulse.
- Single write: port 0 writes 0xBEEF -> data_write=0xBEEF while data_write_done=1, port_write_done[0] high exactly 1 cycle, complete[0]; a read-back via port 2 returns 0xBEEF.
- Contention: ports 0, 2 and 3 request simultaneously -> grants in order 0, 2, 3, then 0 again if still requesting; with SDRAM_ARB_FIXED_PRIORITY_EN, a continuously requesting port 0 wins every time.
- Refresh collision: request issued while the controller refreshes -> command held through ARB_ISSUE with no duplicate transfer; exactly one complete pulse.
- Reset mid-read (during the second valid beat) -> command=0 next cycle, no further port_read_valid, no complete; the next request after reset completes normally.
- Idle / ignored commands: port_req with port_command=0 or 3 -> no grant, controller command stays 0.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// ============================================================================
// sdram_arbiter_pkg : command encodings and arbiter state type
// Revision 1.0
// ============================================================================
`default_nettype none

package sdram_arbiter_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_arbiter_pick.sv
// ============================================================================
// sdram_arbiter_pick : combinational winner select (round-robin, or fixed
// priority when SDRAM_ARB_FIXED_PRIORITY_EN is defined)
// Revision 1.0
// ============================================================================
`default_nettype none

module sdram_arbiter_pick
    import sdram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] winner,
    output logic                 valid
);

    assign valid = |req;

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr;

    always_comb begin
        winner = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner    = '0;
                winner[i] = 1'b1;
            end
        end
    end
`else
    int w_idx;

    // Walk offsets from the highest down so the smallest offset from ptr wins.
    always_comb begin
        winner = '0;
        w_idx  = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_idx = int'(ptr) + i;
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end
            if (req[w_idx]) begin
                winner        = '0;
                winner[w_idx] = 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// sdram_arbiter : shares one sdram_controller between NUM_PORTS requesters.
// Build option: SDRAM_ARB_FIXED_PRIORITY_EN selects fixed priority arbitration.
// Revision 1.0
// ============================================================================
`default_nettype none

module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS          = 4,
    parameter int USER_ADDRESS_WIDTH = 24,
    parameter int DATA_WIDTH         = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_PORTS-1:0]                     port_req,
    input  logic [2*NUM_PORTS-1:0]                   port_command,
    input  logic [USER_ADDRESS_WIDTH*NUM_PORTS-1:0]  port_address,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0]          port_write_data,
    output logic [NUM_PORTS-1:0]                     port_grant,
    output logic [DATA_WIDTH-1:0]                    port_read_data,
    output logic [NUM_PORTS-1:0]                     port_read_valid,
    output logic [NUM_PORTS-1:0]                     port_write_done,
    output logic [NUM_PORTS-1:0]                     port_complete,
    output logic [1:0]                               command,
    output logic [USER_ADDRESS_WIDTH-1:0]            data_address,
    output logic [DATA_WIDTH-1:0]                    data_write,
    input  logic [DATA_WIDTH-1:0]                    data_read,
    input  logic                                     data_read_valid,
    input  logic                                     data_write_done
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t                    r_state;
    logic [1:0]                    r_command;
    logic [USER_ADDRESS_WIDTH-1:0] r_address;
    logic [PTR_W-1:0]              r_owner;
    logic                          r_is_read;
    logic [NUM_PORTS-1:0]          r_grant;
    logic [NUM_PORTS-1:0]          r_complete;

    logic [NUM_PORTS-1:0]          w_req_valid;
    logic [NUM_PORTS-1:0]          w_winner;
    logic                          w_win_valid;
    logic [PTR_W-1:0]              w_win_idx;
    logic [PTR_W-1:0]              w_ptr;
    logic [1:0]                    w_win_cmd;
    logic [USER_ADDRESS_WIDTH-1:0] w_win_addr;
    logic                          w_active;
    logic                          w_resp;

    // Routing is only live while a transfer owns the controller, so stray
    // responses after a reset never reach a port.
    assign w_active = (r_state == ARB_ISSUE) || (r_state == ARB_DRAIN);
    assign w_resp   = r_is_read ? data_read_valid : data_write_done;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [1:0] w_cmd;
        assign w_cmd              = port_command[2*i +: 2];
        assign w_req_valid[i]     = port_req[i] && ((w_cmd == CMD_WRITE) || (w_cmd == CMD_READ));
        assign port_read_valid[i] = w_active && (r_owner == PTR_W'(i)) && data_read_valid;
        assign port_write_done[i] = w_active && (r_owner == PTR_W'(i)) && data_write_done;
    end

    sdram_arbiter_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req    (w_req_valid),
        .ptr    (w_ptr),
        .winner (w_winner),
        .valid  (w_win_valid)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_winner[i]) begin
                w_win_idx = PTR_W'(i);
            end
        end
    end

    assign w_win_cmd  = port_command[2*int'(w_win_idx) +: 2];
    assign w_win_addr = port_address[USER_ADDRESS_WIDTH*int'(w_win_idx) +: USER_ADDRESS_WIDTH];

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
    assign w_ptr = '0;
`else
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if ((r_state == ARB_IDLE) && w_win_valid) begin
            r_ptr <= (w_win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_win_idx + PTR_W'(1);
        end
    end

    assign w_ptr = r_ptr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_command  <= CMD_IDLE;
            r_address  <= '0;
            r_owner    <= '0;
            r_is_read  <= 1'b0;
            r_grant    <= '0;
            r_complete <= '0;
        end else begin
            r_grant    <= '0;
            r_complete <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_win_valid) begin
                        r_grant   <= w_winner;
                        r_command <= w_win_cmd;
                        r_address <= w_win_addr;
                        r_owner   <= w_win_idx;
                        r_is_read <= (w_win_cmd == CMD_READ);
                        r_state   <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // The controller has no busy flag; its first response
                    // is the only evidence the command was taken.
                    if (w_resp) begin
                        r_command <= CMD_IDLE;
                        r_state   <= ARB_DRAIN;
                    end
                end
                ARB_DRAIN: begin
                    if (!w_resp) begin
                        r_complete <= NUM_PORTS'(1) << r_owner;
                        r_state    <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign port_grant     = r_grant;
    assign port_complete  = r_complete;
    assign command        = r_command;
    assign data_address   = r_address;
    assign port_read_data = data_read;
    assign data_write     = w_active ? port_write_data[DATA_WIDTH*int'(r_owner) +: DATA_WIDTH] : '0;

endmodule

`default_nettype wire
